fifo_sync_thr: RTL and testbench
================================

FIFO_SYNC_THR -- requirements
Module: fifo_sync_thr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entry count; power of two, at least 4.
REQ-003 SHALL have parameter AF_THRESH, default FIFO_DEPTH-2, almost-full level; 1 to FIFO_DEPTH-1.
REQ-004 SHALL have parameter AE_THRESH, default 2, almost-empty level; 1 to FIFO_DEPTH-1.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port cs, input, 1, chip select; wr_en, rd_en and flush are ignored while low.
REQ-008 SHALL have port wr_en, input, 1, write request.
REQ-009 SHALL have port rd_en, input, 1, read request.
REQ-010 SHALL have port flush, input, 1, synchronous clear of contents.
REQ-011 SHALL have port clr_err, input, 1, clears sticky error flags.
REQ-012 SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-013 SHALL have port data_out, output, DATA_WIDTH, registered read data.
REQ-014 SHALL have port rd_valid, output, 1, data_out updated this cycle.
REQ-015 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, current occupancy.
REQ-016 SHALL have ports full, empty, almost_full and almost_empty, each output, 1, status flags.
REQ-017 SHALL have ports overflow and underflow, each output, 1, sticky error flags.

Function
REQ-018 SHALL accept a write on an edge when cs, wr_en and !full are all high; data_in goes to mem[wr_ptr] and wr_ptr increments.
REQ-019 SHALL accept a read on an edge when cs, rd_en and !empty are all high; data_out takes mem[rd_ptr] at that edge, rd_ptr increments, and rd_valid is high the following cycle only.
REQ-020 SHALL hold data_out when no read is accepted.
REQ-021 SHALL keep pointers $clog2(FIFO_DEPTH)+1 bits wide, wrapping naturally; index = low bits.
REQ-022 SHALL assert full when pointer MSBs differ and low bits are equal, and empty when the pointers are equal.
REQ-023 SHALL update count at the same edge as the pointers: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 SHALL accept both a read and a write in the same cycle when neither is blocked; when full only the read is accepted, when empty only the write.
REQ-025 SHALL assert almost_full when count >= AF_THRESH and almost_empty when count <= AE_THRESH; the flags are derived from registered state with no extra latency.
REQ-026 SHALL, on cs && flush, zero the pointers and count and drop any same-cycle read or write; data_out is held and rd_valid is low.
REQ-027 SHALL never alter memory or pointers on a rejected request.

Reset
REQ-028 SHALL, when rst_n is low at a clock edge, clear pointers, count, data_out, rd_valid, overflow and underflow to 0; empty and almost_empty become 1, full and almost_full 0.
REQ-029 SHALL give reset priority over flush, reads and writes, including mid-burst; memory contents are not reset.

Configuration
REQ-030 SHALL, with FIFO_SYNC_ERR_FLAGS_EN defined, set overflow on cs && wr_en && full and underflow on cs && rd_en && empty, holding each until clr_err or reset; a set condition coinciding with clr_err leaves the flag set.
REQ-031 SHALL, without FIFO_SYNC_ERR_FLAGS_EN, tie overflow and underflow to 0 and ignore clr_err, keeping the port list unchanged.

Structure
REQ-032 SHALL place the default DATA_WIDTH and FIFO_DEPTH constants, and the pointer/count width helper function, in package fifo_pkg.
REQ-033 SHALL implement storage in sub-module fifo_mem (simple dual-port, one write port, one registered read port); control, pointers and flags stay in fifo_sync_thr.

Verification (DEPTH=8, WIDTH=32, AF=6, AE=2)
REQ-034 SHALL test: 8 writes 0x10..0x17 then 8 reads -> data_out 0x10..0x17 in order, one cycle after each accepted read; full after the 8th write, empty after the 8th read.
REQ-035 SHALL test: 9th write while full, with the macro on -> count stays 8, memory unchanged, overflow=1 until clr_err pulse.
REQ-036 SHALL test: simultaneous read+write at count=8 and at count=0 -> count 7 (read only) and 1 (write only); at count=4 -> count stays 4.
REQ-037 SHALL test: fill to 6 -> almost_full rises on the 6th write edge; drain to 2 -> almost_empty rises.
REQ-038 SHALL test: 20 write/read pairs -> pointers wrap with data intact and no spurious full/empty.
REQ-039 SHALL test: rst_n low, or flush, at count=5 -> count=0, empty=1, following read rejected with underflow=1 (macro on).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helpers for the synchronous threshold FIFO.
// Pointer/count width is one bit wider than the index so full and empty can be told apart.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 8;

    // Accepted request decode, one bit per action taken at the next edge.
    typedef struct packed {
        logic flush;
        logic wr;
        logic rd;
    } req_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
// Latency: read data valid one edge after i_rd_en; no backpressure, caller guarantees legal accesses.
// Backpressure: none; the array itself is not reset, only the read register is.
module fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_dat,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_dat
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_dat;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    // Read register holds its value whenever no read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/fifo_sync_thr.sv
// Synchronous FIFO with almost-full/empty thresholds; sticky errors under FIFO_SYNC_ERR_FLAGS_EN.
// Latency: read data and rd_valid one edge after an accepted read; flags reflect registered state.
// Backpressure: writes rejected while full, reads rejected while empty; cs gates all requests.
module fifo_sync_thr
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cs,
    input  logic                              wr_en,
    input  logic                              rd_en,
    input  logic                              flush,
    input  logic                              clr_err,
    input  logic [DATA_WIDTH-1:0]             data_in,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              rd_valid,
    output logic [ptr_width(FIFO_DEPTH)-1:0]  count,
    output logic                              full,
    output logic                              empty,
    output logic                              almost_full,
    output logic                              almost_empty,
    output logic                              overflow,
    output logic                              underflow
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] AF_LVL  = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL  = PW'(AE_THRESH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_count;
    logic          r_rd_valid;

    logic          w_full;
    logic          w_empty;
    req_t          w_req;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Flush wins over any same-cycle read or write.
    always_comb begin
        w_req       = '0;
        w_req.flush = cs & flush;
        w_req.wr    = cs & wr_en & ~w_full  & ~flush;
        w_req.rd    = cs & rd_en & ~w_empty & ~flush;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_req.flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_req.rd;
            if (w_req.wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_req.rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_req.wr, w_req.rd})
                2'b10:   r_count <= r_count + PTR_ONE;
                2'b01:   r_count <= r_count - PTR_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_req.wr),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_dat  (data_in),
        .i_rd_en   (w_req.rd),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_dat  (data_out)
    );

`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // A set condition outranks clr_err so a coincident error is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (cs && wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (cs && rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_clr_err;
    assign w_unused_clr_err = clr_err;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

    assign rd_valid     = r_rd_valid;
    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_LVL);
    assign almost_empty = (r_count <= AE_LVL);

endmodule

// File: tb/tb_fifo_sync_thr.sv
// Self-checking bench for fifo_sync_thr (DEPTH=8, WIDTH=32, AF=6, AE=2) against a queue model.
// Error-flag expectations follow FIFO_SYNC_ERR_FLAGS_EN as seen by this compilation unit.
module tb_fifo_sync_thr;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic [3:0]    count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_rvld = 1'b0;
    bit            m_ovf  = 1'b0;
    bit            m_udf  = 1'b0;

    fifo_sync_thr #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs           (cs),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .flush        (flush),
        .clr_err      (clr_err),
        .data_in      (data_in),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle, advance the model by the spec's rules, sample #1 after the edge.
    task automatic cycle(input bit c, input bit w, input bit r, input bit f, input bit ce,
                         input logic [DW-1:0] d);
        bit m_full, m_empty, rd_ok, wr_ok;
        cs = c; wr_en = w; rd_en = r; flush = f; clr_err = ce; data_in = d;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_dout = '0; m_rvld = 0; m_ovf = 0; m_udf = 0;
        end else begin
            m_full  = (q.size() == DEPTH);
            m_empty = (q.size() == 0);
            if (ERR_EN) begin
                if (c && w && m_full) m_ovf = 1; else if (ce) m_ovf = 0;
                if (c && r && m_empty) m_udf = 1; else if (ce) m_udf = 0;
            end
            if (c && f) begin
                q.delete();
                m_rvld = 0;
            end else begin
                rd_ok = c && r && !m_empty;
                wr_ok = c && w && !m_full;
                if (rd_ok) m_dout = q.pop_front();
                m_rvld = rd_ok;
                if (wr_ok) q.push_back(d);
            end
        end
        #1;
    endtask

    task automatic clean();
        cycle(1, 0, 0, 1, 1, '0);
        cycle(0, 0, 0, 0, 1, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1, 1, 1, 0, 0, 32'hAA);
        cycle(1, 1, 1, 0, 0, 32'hBB);
        rst_n = 1'b1;
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin
            bad++; $display("FAIL reset_flags: got %b want 0101", {full, empty, almost_full, almost_empty});
        end
        total++; if (data_out !== '0 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL reset_rd: got dout=%0h vld=%b want 0/0", data_out, rd_valid);
        end
        total++; if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL reset_err: got %b want 00", {overflow, underflow});
        end
    endtask

    task automatic test_fill_drain();
        clean();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 1, 0, 0, 0, 32'h10 + i);
            total++; if (count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full); end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 1, 0, 0, '0);
            total++; if (rd_valid !== 1'b1 || data_out !== 32'h10 + i) begin
                bad++; $display("FAIL drain_data: got vld=%b dout=%0h want 1/%0h", rd_valid, data_out, 32'h10 + i);
            end
        end
        total++; if (empty !== 1'b1 || full !== 1'b0) begin
            bad++; $display("FAIL drain_empty: got e=%b f=%b want 1/0", empty, full);
        end
        cycle(1, 0, 0, 0, 0, '0);
        total++; if (rd_valid !== 1'b0 || data_out !== 32'h17) begin
            bad++; $display("FAIL idle_hold: got vld=%b dout=%0h want 0/17", rd_valid, data_out);
        end
    endtask

    task automatic test_overflow();
        clean();
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, 0, 0, 32'hA0 + i);
        cycle(1, 1, 0, 0, 0, 32'hDEADBEEF);
        total++; if (count !== 4'd8 || full !== 1'b1) begin
            bad++; $display("FAIL ovf_count: got %0d full=%b want 8/1", count, full);
        end
        total++; if (overflow !== ERR_EN) begin bad++; $display("FAIL ovf_set: got %b want %b", overflow, ERR_EN); end
        cycle(1, 1, 0, 0, 1, 32'hDEADBEEF);
        total++; if (overflow !== ERR_EN) begin bad++; $display("FAIL ovf_set_vs_clr: got %b want %b", overflow, ERR_EN); end
        cycle(1, 0, 0, 0, 0, '0);
        total++; if (overflow !== ERR_EN) begin bad++; $display("FAIL ovf_sticky: got %b want %b", overflow, ERR_EN); end
        cycle(0, 0, 0, 0, 1, '0);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 1, 0, 0, '0);
            total++; if (data_out !== 32'hA0 + i) begin
                bad++; $display("FAIL ovf_mem: got %0h want %0h", data_out, 32'hA0 + i);
            end
        end
    endtask

    task automatic test_simul();
        clean();
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, 0, 0, 32'hB0 + i);
        cycle(1, 1, 1, 0, 0, 32'hC0);
        total++; if (count !== 4'd7 || rd_valid !== 1'b1 || data_out !== 32'hB0) begin
            bad++; $display("FAIL simul_full: got cnt=%0d vld=%b dout=%0h want 7/1/b0", count, rd_valid, data_out);
        end
        while (q.size() > 0) cycle(1, 0, 1, 0, 0, '0);
        total++; if (data_out !== 32'hB7) begin bad++; $display("FAIL simul_last: got %0h want b7", data_out); end
        cycle(1, 1, 1, 0, 0, 32'hD0);
        total++; if (count !== 4'd1 || rd_valid !== 1'b0) begin
            bad++; $display("FAIL simul_empty: got cnt=%0d vld=%b want 1/0", count, rd_valid);
        end
        total++; if (underflow !== ERR_EN) begin bad++; $display("FAIL simul_udf: got %b want %b", underflow, ERR_EN); end
        cycle(1, 1, 0, 0, 1, 32'hD1);
        cycle(1, 1, 0, 0, 0, 32'hD2);
        cycle(1, 1, 0, 0, 0, 32'hD3);
        cycle(1, 1, 1, 0, 0, 32'hD4);
        total++; if (count !== 4'd4 || data_out !== 32'hD0) begin
            bad++; $display("FAIL simul_mid: got cnt=%0d dout=%0h want 4/d0", count, data_out);
        end
    endtask

    task automatic test_thresholds();
        clean();
        for (int n = 1; n <= AF; n++) begin
            cycle(1, 1, 0, 0, 0, 32'(n));
            total++; if (almost_full !== (n >= AF) || almost_empty !== (n <= AE)) begin
                bad++; $display("FAIL thr_fill n=%0d: got af=%b ae=%b", n, almost_full, almost_empty);
            end
        end
        for (int n = AF - 1; n >= AE; n--) begin
            cycle(1, 0, 1, 0, 0, '0);
            total++; if (almost_full !== (n >= AF) || almost_empty !== (n <= AE)) begin
                bad++; $display("FAIL thr_drain n=%0d: got af=%b ae=%b", n, almost_full, almost_empty);
            end
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d;
        clean();
        for (int i = 0; i < 20; i++) begin
            d = $urandom;
            cycle(1, 1, 0, 0, 0, d);
            total++; if (count !== 4'd1 || full !== 1'b0 || empty !== 1'b0) begin
                bad++; $display("FAIL wrap_wr %0d: got cnt=%0d f=%b e=%b want 1/0/0", i, count, full, empty);
            end
            cycle(1, 0, 1, 0, 0, '0);
            total++; if (data_out !== d || empty !== 1'b1 || full !== 1'b0) begin
                bad++; $display("FAIL wrap_rd %0d: got dout=%0h e=%b want %0h/1", i, data_out, empty, d);
            end
        end
    endtask

    task automatic test_flush_reset();
        clean();
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, 32'hE0 + i);
        cycle(1, 1, 1, 1, 0, 32'hEE);
        total++; if (count !== 4'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || data_out !== m_dout) begin
            bad++; $display("FAIL flush: got cnt=%0d e=%b vld=%b dout=%0h want 0/1/0/%0h",
                            count, empty, rd_valid, data_out, m_dout);
        end
        cycle(1, 0, 1, 0, 0, '0);
        total++; if (rd_valid !== 1'b0 || underflow !== ERR_EN) begin
            bad++; $display("FAIL flush_udf: got vld=%b udf=%b want 0/%b", rd_valid, underflow, ERR_EN);
        end
        cycle(0, 0, 0, 0, 1, '0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, 32'hF0 + i);
        cycle(1, 0, 1, 0, 0, '0);
        rst_n = 1'b0;
        cycle(1, 1, 1, 0, 0, 32'hFF);
        rst_n = 1'b1;
        total++; if (count !== 4'd0 || empty !== 1'b1 || data_out !== '0) begin
            bad++; $display("FAIL rst_mid: got cnt=%0d e=%b dout=%0h want 0/1/0", count, empty, data_out);
        end
        cycle(1, 0, 1, 0, 0, '0);
        total++; if (rd_valid !== 1'b0 || underflow !== ERR_EN) begin
            bad++; $display("FAIL rst_udf: got vld=%b udf=%b want 0/%b", rd_valid, underflow, ERR_EN);
        end
    endtask

    task automatic test_random();
        logic [6:0] exp_st;
        clean();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, $urandom);
            exp_st = {q.size() == DEPTH, q.size() == 0, q.size() >= AF, q.size() <= AE, m_ovf, m_udf, m_rvld};
            total++; if (count !== 4'(q.size())) begin
                bad++; $display("FAIL rand_count %0d: got %0d want %0d", i, count, q.size());
            end
            total++; if ({full, empty, almost_full, almost_empty, overflow, underflow, rd_valid} !== exp_st) begin
                bad++; $display("FAIL rand_status %0d: got %b want %b", i,
                                {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid}, exp_st);
            end
            total++; if (data_out !== m_dout) begin
                bad++; $display("FAIL rand_dout %0d: got %0h want %0h", i, data_out, m_dout);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simul();
        test_thresholds();
        test_wrap();
        test_flush_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
